reference_buffer_sequencer: RTL

// - Sequences index reads into the reference sample buffer over a valid/ready index stream.
// - Sweeps a configured window [start_index, start_index+sweep_length) for num_passes passes
//   (e.g. one pass per CAF frequency bin).
// - Drains the 2-cycle buffer read latency, then reports completion.
// - Sits between the CAF top-level control and the reference buffer index port.

---
 rtl/reference_buffer_sequencer.sv | 183 ++++++++++++++++++
 1 files changed

// File: rtl/reference_buffer_sequencer.sv
// -----------------------------------------------------------------------------
// reference_buffer_sequencer
//
// Streams read indices into the reference sample buffer. A window
// [start_index, start_index+sweep_length) is swept num_passes times, with no
// bubbles between passes. After the final index is accepted, the buffer read
// latency is drained and a one-cycle done pulse is issued.
//
// Optional feature macro: REF_SEQ_WRAP_EN
//   defined   : the window is circular, index = (start_index+offset) mod
//               buffer_length; only sweep_length > buffer_length is rejected.
//   undefined : a window running past the end of the buffer is rejected and
//               no wrap logic is built.
//
// Ports
//   clk, rst               clock, asynchronous active-high reset
//   start                  one-cycle sweep request (honoured in IDLE only)
//   start_index            first index of the window
//   sweep_length           indices per pass
//   num_passes             number of passes
//   m_axis_tready          downstream ready
//   m_axis_index_tvalid    index valid (high throughout RUN)
//   m_axis_index_tdata     index to the buffer
//   pass_index             current pass, 0-based
//   busy                   high in RUN and DRAIN
//   done                   pulse once the final data has left the buffer
//   cfg_error              pulse when a start request is rejected
// -----------------------------------------------------------------------------
module reference_buffer_sequencer #(
   parameter int buffer_length = 10,
   parameter int index_bits    = 4,
   parameter int pass_bits     = 8,
   parameter int read_latency  = 2
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  start,
   input  logic [index_bits-1:0] start_index,
   input  logic [index_bits-1:0] sweep_length,
   input  logic [pass_bits-1:0]  num_passes,
   input  logic                  m_axis_tready,
   output logic                  m_axis_index_tvalid,
   output logic [index_bits-1:0] m_axis_index_tdata,
   output logic [pass_bits-1:0]  pass_index,
   output logic                  busy,
   output logic                  done,
   output logic                  cfg_error
);

   localparam int DCW = (read_latency > 1) ? $clog2(read_latency) : 1;
   localparam logic [index_bits:0] BUF_LEN = (index_bits+1)'(buffer_length);

   typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

   state_t                state_q, state_d;
   logic [index_bits-1:0] tdata_q, tdata_d;
   logic [index_bits:0]   offset_q, offset_d;
   logic [pass_bits-1:0]  pass_q, pass_d;
   logic [index_bits-1:0] base_q, base_d;
   logic [index_bits-1:0] len_q, len_d;
   logic [pass_bits-1:0]  passes_q, passes_d;
   logic [DCW-1:0]        drain_q, drain_d;
   logic                  done_q, done_d;
   logic                  err_q, err_d;

   logic                  cfg_bad;
   logic                  last_off;
   logic                  last_pass;
   logic [index_bits-1:0] next_idx;

`ifdef REF_SEQ_WRAP_EN
   localparam logic [index_bits-1:0] IDX_LAST = index_bits'(buffer_length - 1);

   // Circular window: only a window longer than the buffer is meaningless.
   assign cfg_bad = (sweep_length == '0) || (num_passes == '0) ||
                    ({1'b0, start_index} >= BUF_LEN) ||
                    ({1'b0, sweep_length} > BUF_LEN);
   assign next_idx = (tdata_q == IDX_LAST) ? '0 : tdata_q + index_bits'(1);
`else
   logic [index_bits:0] win_end;

   // One extra bit so start_index+sweep_length cannot alias past the buffer end.
   assign win_end  = {1'b0, start_index} + {1'b0, sweep_length};
   assign cfg_bad  = (sweep_length == '0) || (num_passes == '0) ||
                     ({1'b0, start_index} >= BUF_LEN) || (win_end > BUF_LEN);
   assign next_idx = tdata_q + index_bits'(1);
`endif

   assign last_off  = (offset_q == ({1'b0, len_q} - (index_bits+1)'(1)));
   assign last_pass = (pass_q == (passes_q - pass_bits'(1)));

   always_comb begin
      state_d  = state_q;
      tdata_d  = tdata_q;
      offset_d = offset_q;
      pass_d   = pass_q;
      base_d   = base_q;
      len_d    = len_q;
      passes_d = passes_q;
      drain_d  = drain_q;
      done_d   = 1'b0;
      err_d    = 1'b0;
      case (state_q)
         IDLE: begin
            if (start) begin
               if (cfg_bad) begin
                  err_d = 1'b1;
               end else begin
                  base_d   = start_index;
                  len_d    = sweep_length;
                  passes_d = num_passes;
                  offset_d = '0;
                  pass_d   = '0;
                  tdata_d  = start_index;
                  state_d  = RUN;
               end
            end
         end
         RUN: begin
            if (m_axis_tready) begin
               if (last_off) begin
                  if (last_pass) begin
                     drain_d = '0;
                     state_d = DRAIN;
                  end else begin
                     // Pass boundary: restart the window, bump pass on the same edge.
                     offset_d = '0;
                     tdata_d  = base_q;
                     pass_d   = pass_q + pass_bits'(1);
                  end
               end else begin
                  offset_d = offset_q + (index_bits+1)'(1);
                  tdata_d  = next_idx;
               end
            end
         end
         DRAIN: begin
            // done lands in the first IDLE cycle, read_latency+1 after the last transfer.
            if (drain_q == DCW'(read_latency - 1)) begin
               done_d  = 1'b1;
               state_d = IDLE;
            end else begin
               drain_d = drain_q + DCW'(1);
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= IDLE;
         tdata_q  <= '0;
         offset_q <= '0;
         pass_q   <= '0;
         base_q   <= '0;
         len_q    <= '0;
         passes_q <= '0;
         drain_q  <= '0;
         done_q   <= 1'b0;
         err_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         tdata_q  <= tdata_d;
         offset_q <= offset_d;
         pass_q   <= pass_d;
         base_q   <= base_d;
         len_q    <= len_d;
         passes_q <= passes_d;
         drain_q  <= drain_d;
         done_q   <= done_d;
         err_q    <= err_d;
      end
   end

   assign m_axis_index_tvalid = (state_q == RUN);
   assign m_axis_index_tdata  = tdata_q;
   assign pass_index          = pass_q;
   assign busy                = (state_q != IDLE);
   assign done                = done_q;
   assign cfg_error           = err_q;

endmodule
